// File: rtl/latch_write_sequencer_pkg.sv
// Shared types and helpers for the latch write sequencer.
// Holds the FSM state encoding and the phase-counter width calculation.
package latch_write_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_PRESET = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_PULSE  = 3'd3,
      ST_HOLD   = 3'd4
   } lws_state_t;

   // Counter loads (phase length - 1), so clog2 of the longest phase suffices.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/latch_write_sequencer_phase_timer.sv
// Loadable down-counter with terminal-count flag, shared by all sequencer phases.
// Loading N-1 makes tc rise after N cycles in the phase.
module latch_write_sequencer_phase_timer #(
   parameter int             CW      = 1,
   parameter logic [CW-1:0]  RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tc
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= RST_VAL;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Write sequencer for a transparent latch bank with active-low gate and async preset.
// All latch-side outputs are registered from the next state so they never glitch.
module latch_write_sequencer #(
   parameter int WIDTH     = 4,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1,
   parameter int PRE_CYC   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             preset_req,
   output logic [WIDTH-1:0] lat_d,
   output logic             lat_g_n,
   output logic             lat_pre,
   output logic [WIDTH-1:0] shadow,
   output logic             busy,
   output logic             done
);

   import latch_write_sequencer_pkg::*;

   localparam int            CW       = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC, PRE_CYC);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] PRE_LD   = CW'(PRE_CYC - 1);

   lws_state_t       state, state_nxt;
   logic             tmr_load;
   logic [CW-1:0]    tmr_val;
   logic             tmr_tc;
   logic [WIDTH-1:0] lat_d_nxt;
   logic [WIDTH-1:0] shadow_nxt;
   logic             done_nxt;

   // Counter comes out of reset preloaded so the reset preset lasts PRE_CYC cycles.
   latch_write_sequencer_phase_timer #(
      .CW      (CW),
      .RST_VAL (PRE_LD)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_nxt  = state;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      lat_d_nxt  = lat_d;
      shadow_nxt = shadow;
      done_nxt   = 1'b0;
      case (state)
         ST_PRESET: begin
            if (tmr_tc) begin
               state_nxt  = ST_IDLE;
               shadow_nxt = '1;
               done_nxt   = 1'b1;
            end
         end
         ST_IDLE: begin
            // Preset has priority; a simultaneous write is simply not taken.
            if (preset_req) begin
               state_nxt = ST_PRESET;
               tmr_load  = 1'b1;
               tmr_val   = PRE_LD;
            end else if (wr_valid) begin
               state_nxt = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_val   = SETUP_LD;
               lat_d_nxt = wr_data;
            end
         end
         ST_SETUP: begin
            if (tmr_tc) begin
               state_nxt = ST_PULSE;
               tmr_load  = 1'b1;
               tmr_val   = PULSE_LD;
            end
         end
         ST_PULSE: begin
            if (tmr_tc) begin
               state_nxt = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_val   = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_tc) begin
               state_nxt  = ST_IDLE;
               shadow_nxt = lat_d;
               done_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_PRESET;
            tmr_load  = 1'b1;
            tmr_val   = PRE_LD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_PRESET;
         lat_pre  <= 1'b1;
         lat_g_n  <= 1'b1;
         lat_d    <= '0;
         shadow   <= '1;
         wr_ready <= 1'b0;
         busy     <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         lat_pre  <= (state_nxt == ST_PRESET);
         lat_g_n  <= (state_nxt != ST_PULSE);
         lat_d    <= lat_d_nxt;
         shadow   <= shadow_nxt;
         wr_ready <= (state_nxt == ST_IDLE);
         busy     <= (state_nxt != ST_IDLE);
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: default-parameter instance plus a 3/1/2 timing instance.
// Stimulus queues expected completions; monitors check them when DONE pulses.
module tb_latch_write_sequencer;

   localparam int S0 = 1, P0 = 2, H0 = 1, PR = 2;
   localparam int S1 = 3, P1 = 1, H1 = 2;

   typedef struct {
      logic [3:0] shadow;
      int         gate;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   int         cyc = 0;
   int         total = 0;
   int         passed = 0;
   exp_t       q0[$];
   exp_t       q1[$];
   exp_t       e0, e1;

   logic       rst_n0, wr_valid0, preset_req0, wr_ready0, lat_g_n0, lat_pre0, busy0, done0;
   logic [3:0] wr_data0, lat_d0, shadow0;
   logic       rst_n1, wr_valid1, preset_req1, wr_ready1, lat_g_n1, lat_pre1, busy1, done1;
   logic [3:0] wr_data1, lat_d1, shadow1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   latch_write_sequencer #(
      .WIDTH(4), .SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0), .PRE_CYC(PR)
   ) dut0 (
      .clk(clk), .rst_n(rst_n0), .wr_data(wr_data0), .wr_valid(wr_valid0),
      .wr_ready(wr_ready0), .preset_req(preset_req0), .lat_d(lat_d0),
      .lat_g_n(lat_g_n0), .lat_pre(lat_pre0), .shadow(shadow0), .busy(busy0), .done(done0)
   );

   latch_write_sequencer #(
      .WIDTH(4), .SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1), .PRE_CYC(PR)
   ) dut1 (
      .clk(clk), .rst_n(rst_n1), .wr_data(wr_data1), .wr_valid(wr_valid1),
      .wr_ready(wr_ready1), .preset_req(preset_req1), .lat_d(lat_d1),
      .lat_g_n(lat_g_n1), .lat_pre(lat_pre1), .shadow(shadow1), .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
   endtask

   // Monitor for the default instance: gate-low length, data stability, completions.
   int         glow0 = 0;
   logic [3:0] dgate0;
   always @(negedge clk) begin
      if (!rst_n0) begin
         glow0 = 0;
      end else begin
         if (!lat_g_n0) begin
            if (glow0 == 0) dgate0 = lat_d0;
            else check("d_stable_gate0", lat_d0, dgate0);
            check("pre_low_while_gate0", lat_pre0, 0);
            glow0++;
         end
         if (done0) begin
            if (q0.size() == 0) begin
               total++;
               $display("FAIL done0_unexpected: got done=1 expected no completion at cycle %0d", cyc);
            end else begin
               e0 = q0.pop_front();
               check("shadow0_at_done", shadow0, e0.shadow);
               check("gate0_low_cycles", glow0, e0.gate);
               check("done0_cycle", cyc, e0.cyc);
               check("ready0_at_done", wr_ready0, 1);
            end
            glow0 = 0;
         end
      end
   end

   int         glow1 = 0;
   logic [3:0] dgate1;
   always @(negedge clk) begin
      if (!rst_n1) begin
         glow1 = 0;
      end else begin
         if (!lat_g_n1) begin
            if (glow1 == 0) dgate1 = lat_d1;
            else check("d_stable_gate1", lat_d1, dgate1);
            check("pre_low_while_gate1", lat_pre1, 0);
            glow1++;
         end
         if (done1) begin
            if (q1.size() == 0) begin
               total++;
               $display("FAIL done1_unexpected: got done=1 expected no completion at cycle %0d", cyc);
            end else begin
               e1 = q1.pop_front();
               check("shadow1_at_done", shadow1, e1.shadow);
               check("gate1_low_cycles", glow1, e1.gate);
               check("done1_cycle", cyc, e1.cyc);
            end
            glow1 = 0;
         end
      end
   end

   task automatic wait_ready0();
      @(negedge clk);
      for (int i = 0; i < 50 && !wr_ready0; i++) @(negedge clk);
      if (!wr_ready0) check("ready0_timeout", wr_ready0, 1);
   endtask

   task automatic wait_ready1();
      @(negedge clk);
      for (int i = 0; i < 50 && !wr_ready1; i++) @(negedge clk);
      if (!wr_ready1) check("ready1_timeout", wr_ready1, 1);
   endtask

   task automatic write0(input logic [3:0] d);
      wait_ready0();
      wr_data0  = d;
      wr_valid0 = 1'b1;
      @(posedge clk); #1;
      q0.push_back('{d, P0, cyc + S0 + P0 + H0});
      wr_valid0 = 1'b0;
      @(negedge clk);
      check("lat_d0_after_accept", lat_d0, d);
      check("gate0_high_in_setup", lat_g_n0, 1);
      check("ready0_low_busy", wr_ready0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
      $fatal(1);
   end

   initial begin
      rst_n0 = 1'b0; wr_valid0 = 1'b0; preset_req0 = 1'b0; wr_data0 = 4'h0;
      rst_n1 = 1'b0; wr_valid1 = 1'b0; preset_req1 = 1'b0; wr_data1 = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_lat_pre", lat_pre0, 1);
      check("rst_lat_g_n", lat_g_n0, 1);
      check("rst_lat_d", lat_d0, 0);
      check("rst_shadow", shadow0, 4'hF);
      check("rst_wr_ready", wr_ready0, 0);
      check("rst_busy", busy0, 1);
      check("rst_done", done0, 0);
      check("rst_lat_pre1", lat_pre1, 1);

      // Release reset: preset lasts PR more cycles, then DONE.
      @(posedge clk); #1;
      q0.push_back('{4'hF, 0, cyc + PR});
      q1.push_back('{4'hF, 0, cyc + PR});
      rst_n0 = 1'b1;
      rst_n1 = 1'b1;
      @(negedge clk);
      check("pre_held_after_release", lat_pre0, 1);
      wait_ready0();
      check("idle_busy0", busy0, 0);
      check("idle_pre0", lat_pre0, 0);

      write0(4'hA);

      // Held valid: two back-to-back writes.
      wait_ready0();
      wr_data0  = 4'h3;
      wr_valid0 = 1'b1;
      @(posedge clk); #1;
      q0.push_back('{4'h3, P0, cyc + S0 + P0 + H0});
      wr_data0 = 4'h5;
      @(negedge clk);
      check("b2b_ready_low", wr_ready0, 0);
      check("b2b_first_data", lat_d0, 4'h3);
      for (int i = 0; i < 50 && !wr_ready0; i++) @(negedge clk);
      check("b2b_ready_again", wr_ready0, 1);
      @(posedge clk); #1;
      q0.push_back('{4'h5, P0, cyc + S0 + P0 + H0});
      wr_valid0 = 1'b0;
      @(negedge clk);
      check("b2b_second_data", lat_d0, 4'h5);

      // Reset dropped during the gate pulse; partial write must vanish.
      wait_ready0();
      wr_data0  = 4'h9;
      wr_valid0 = 1'b1;
      @(posedge clk); #1;
      wr_valid0 = 1'b0;
      @(posedge clk); #1;
      check("gate0_open_in_pulse", lat_g_n0, 0);
      rst_n0 = 1'b0;
      #1;
      check("async_rst_gate", lat_g_n0, 1);
      check("async_rst_pre", lat_pre0, 1);
      check("async_rst_shadow", shadow0, 4'hF);
      check("async_rst_done", done0, 0);
      repeat (2) @(posedge clk);
      #1;
      q0.push_back('{4'hF, 0, cyc + PR});
      rst_n0 = 1'b1;

      write0(4'hC);

      // Preset and write requested together: preset wins.
      wait_ready0();
      preset_req0 = 1'b1;
      wr_valid0   = 1'b1;
      wr_data0    = 4'h0;
      @(posedge clk); #1;
      q0.push_back('{4'hF, 0, cyc + PR});
      preset_req0 = 1'b0;
      wr_valid0   = 1'b0;
      @(negedge clk);
      check("preset_pre_high", lat_pre0, 1);
      check("preset_ready_low", wr_ready0, 0);
      check("preset_write_dropped", lat_d0, 4'hC);
      check("preset_gate_closed", lat_g_n0, 1);

      // Non-default timing instance.
      wait_ready1();
      wr_data1  = 4'h6;
      wr_valid1 = 1'b1;
      @(posedge clk); #1;
      q1.push_back('{4'h6, P1, cyc + S1 + P1 + H1});
      wr_valid1 = 1'b0;
      @(negedge clk);
      check("lat_d1_after_accept", lat_d1, 4'h6);
      check("gate1_setup_0", lat_g_n1, 1);
      for (int i = 1; i < S1; i++) begin
         @(negedge clk);
         check("gate1_setup_n", lat_g_n1, 1);
      end
      @(negedge clk);
      check("gate1_opens", lat_g_n1, 0);
      @(negedge clk);
      check("gate1_closes", lat_g_n1, 1);

      wait_ready0();
      wait_ready1();
      repeat (3) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
